// File: rtl/core_writeback_arbiter_pkg.sv
// Shared types for the writeback arbiter: register/word widths, result payload,
// source indices and the number of register-file write ports.
package core_writeback_arbiter_pkg;

  localparam int WB_NUM_SRC = 4;
  localparam int WB_PORTS   = 2;
  localparam int REG_W      = 4;
  localparam int WORD_W     = 32;
  localparam int HWORD_W    = 16;

  typedef logic [REG_W-1:0]   reg_num;
  typedef logic [WORD_W-1:0]  word;
  typedef logic [HWORD_W-1:0] hword;

  typedef struct packed {
    reg_num rd;
    word    value;
  } wb_req;

  typedef enum logic [1:0] {
    WB_ALU_A = 2'd0,
    WB_ALU_B = 2'd1,
    WB_MUL   = 2'd2,
    WB_LDST  = 2'd3
  } wb_src;

  function automatic hword rd_onehot(input reg_num rd);
    return hword'(1) << rd;
  endfunction

endpackage

// File: rtl/core_writeback_arbiter_slot.sv
// One-entry park slot for a single writeback source. Presents either the parked
// entry or the live input as this source's arbitration candidate.
module core_wb_slot
  import core_writeback_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  input  wb_req in_req,
  input  logic  lose,
  input  logic  grant,
  output logic  ready,
  output logic  cand_valid,
  output logic  cand_parked,
  output wb_req cand_req,
  output hword  pending_onehot
);

  logic  slot_valid_reg;
  logic  slot_valid_next;
  wb_req slot_req_reg;
  wb_req slot_req_next;

  // Ready comes only from the slot flop so producers never see a comb path from valid.
  assign ready          = !slot_valid_reg;
  assign cand_parked    = slot_valid_reg;
  assign cand_valid     = slot_valid_reg || in_valid;
  assign cand_req       = slot_valid_reg ? slot_req_reg : in_req;
  assign pending_onehot = slot_valid_reg ? rd_onehot(slot_req_reg.rd) : '0;

  always_comb begin
    slot_valid_next = slot_valid_reg;
    slot_req_next   = slot_req_reg;
    if (slot_valid_reg) begin
      if (grant) begin
        slot_valid_next = 1'b0;
      end
    end else if (in_valid && lose) begin
      slot_valid_next = 1'b1;
      slot_req_next   = in_req;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_valid_reg <= 1'b0;
      slot_req_reg   <= '0;
    end else begin
      slot_valid_reg <= slot_valid_next;
      slot_req_reg   <= slot_req_next;
    end
  end

endmodule

// File: rtl/core_writeback_arbiter.sv
// Arbitrates four execution-unit results onto two registered register-file write
// ports; losers park in per-source slots and are exported as a pending mask.
module core_writeback_arbiter
  import core_writeback_arbiter_pkg::*;
#(
  parameter int NUM_SRC = WB_NUM_SRC
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   wb_valid_alu_a,
  input  logic   wb_valid_alu_b,
  input  logic   wb_valid_mul,
  input  logic   wb_valid_ldst,
  input  reg_num wb_rd_alu_a,
  input  reg_num wb_rd_alu_b,
  input  reg_num wb_rd_mul,
  input  reg_num wb_rd_ldst,
  input  word    wb_value_alu_a,
  input  word    wb_value_alu_b,
  input  word    wb_value_mul,
  input  word    wb_value_ldst,
  output logic   wb_ready_alu_a,
  output logic   wb_ready_alu_b,
  output logic   wb_ready_mul,
  output logic   wb_ready_ldst,
  output logic   wr_en_a,
  output logic   wr_en_b,
  output reg_num wr_r_a,
  output reg_num wr_r_b,
  output word    wr_value_a,
  output word    wr_value_b,
  output hword   pending_mask
);

  logic [NUM_SRC-1:0] in_valid;
  logic [NUM_SRC-1:0] slot_ready;
  logic [NUM_SRC-1:0] cand_valid;
  logic [NUM_SRC-1:0] cand_parked;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] lose;
  wb_req              in_req      [NUM_SRC];
  wb_req              cand_req    [NUM_SRC];
  hword               pend_onehot [NUM_SRC];

  wb_src                order_src [2*NUM_SRC];
  logic [2*NUM_SRC-1:0] order_elig;

  int    n_grant;
  logic  grant_a_vld;
  wb_src grant_a_src;
  logic  grant_b_vld;
  wb_src grant_b_src;

  logic  rr_ptr_reg;
  logic  rr_ptr_next;
  wb_src rr_fav;

  logic   wr_en_a_reg, wr_en_a_next;
  logic   wr_en_b_reg, wr_en_b_next;
  reg_num wr_r_a_reg,  wr_r_a_next;
  reg_num wr_r_b_reg,  wr_r_b_next;
  word    wr_value_a_reg, wr_value_a_next;
  word    wr_value_b_reg, wr_value_b_next;

  assign in_valid[WB_ALU_A] = wb_valid_alu_a;
  assign in_valid[WB_ALU_B] = wb_valid_alu_b;
  assign in_valid[WB_MUL]   = wb_valid_mul;
  assign in_valid[WB_LDST]  = wb_valid_ldst;

  assign in_req[WB_ALU_A] = '{rd: wb_rd_alu_a, value: wb_value_alu_a};
  assign in_req[WB_ALU_B] = '{rd: wb_rd_alu_b, value: wb_value_alu_b};
  assign in_req[WB_MUL]   = '{rd: wb_rd_mul,   value: wb_value_mul};
  assign in_req[WB_LDST]  = '{rd: wb_rd_ldst,  value: wb_value_ldst};

  assign wb_ready_alu_a = slot_ready[WB_ALU_A];
  assign wb_ready_alu_b = slot_ready[WB_ALU_B];
  assign wb_ready_mul   = slot_ready[WB_MUL];
  assign wb_ready_ldst  = slot_ready[WB_LDST];

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slot
      core_wb_slot u_slot (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid[gi]),
        .in_req         (in_req[gi]),
        .lose           (lose[gi]),
        .grant          (grant[gi]),
        .ready          (slot_ready[gi]),
        .cand_valid     (cand_valid[gi]),
        .cand_parked    (cand_parked[gi]),
        .cand_req       (cand_req[gi]),
        .pending_onehot (pend_onehot[gi])
      );
    end
  endgenerate

  assign lose   = cand_valid & ~grant;
  assign rr_fav = rr_ptr_reg ? WB_LDST : WB_MUL;

  // Priority list: every parked entry first, then fresh ALUs, then the fresh mul/ldst pair in rr order.
  always_comb begin
    for (int p = 0; p < NUM_SRC; p++) begin
      order_src[p] = wb_src'(p);
    end
    order_src[NUM_SRC+0] = WB_ALU_A;
    order_src[NUM_SRC+1] = WB_ALU_B;
    order_src[NUM_SRC+2] = rr_ptr_reg ? WB_LDST : WB_MUL;
    order_src[NUM_SRC+3] = rr_ptr_reg ? WB_MUL : WB_LDST;
    order_elig = '0;
    for (int p = 0; p < 2*NUM_SRC; p++) begin
      if (p < NUM_SRC) begin
        order_elig[p] = cand_parked[order_src[p]];
      end else begin
        order_elig[p] = cand_valid[order_src[p]] && !cand_parked[order_src[p]];
      end
    end
  end

  // Walk the list; a candidate whose rd matches the port A grant is skipped (it loses).
  always_comb begin
    grant       = '0;
    n_grant     = 0;
    grant_a_vld = 1'b0;
    grant_a_src = WB_ALU_A;
    grant_b_vld = 1'b0;
    grant_b_src = WB_ALU_A;
    for (int p = 0; p < 2*NUM_SRC; p++) begin
      if (order_elig[p] && (n_grant < WB_PORTS)) begin
        if (n_grant == 0) begin
          grant_a_vld             = 1'b1;
          grant_a_src             = order_src[p];
          grant[order_src[p]]     = 1'b1;
          n_grant                 = 1;
        end else if (cand_req[order_src[p]].rd != cand_req[grant_a_src].rd) begin
          grant_b_vld             = 1'b1;
          grant_b_src             = order_src[p];
          grant[order_src[p]]     = 1'b1;
          n_grant                 = 2;
        end
      end
    end
  end

  always_comb begin
    wr_en_a_next    = grant_a_vld;
    wr_r_a_next     = grant_a_vld ? cand_req[grant_a_src].rd : '0;
    wr_value_a_next = grant_a_vld ? cand_req[grant_a_src].value : '0;
    wr_en_b_next    = grant_b_vld;
    wr_r_b_next     = grant_b_vld ? cand_req[grant_b_src].rd : '0;
    wr_value_b_next = grant_b_vld ? cand_req[grant_b_src].value : '0;
    rr_ptr_next     = rr_ptr_reg;
    if (grant[rr_fav] && !cand_parked[rr_fav]) begin
      rr_ptr_next = !rr_ptr_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_reg     <= 1'b0;
      wr_en_a_reg    <= 1'b0;
      wr_r_a_reg     <= '0;
      wr_value_a_reg <= '0;
      wr_en_b_reg    <= 1'b0;
      wr_r_b_reg     <= '0;
      wr_value_b_reg <= '0;
    end else begin
      rr_ptr_reg     <= rr_ptr_next;
      wr_en_a_reg    <= wr_en_a_next;
      wr_r_a_reg     <= wr_r_a_next;
      wr_value_a_reg <= wr_value_a_next;
      wr_en_b_reg    <= wr_en_b_next;
      wr_r_b_reg     <= wr_r_b_next;
      wr_value_b_reg <= wr_value_b_next;
    end
  end

  assign wr_en_a    = wr_en_a_reg;
  assign wr_r_a     = wr_r_a_reg;
  assign wr_value_a = wr_value_a_reg;
  assign wr_en_b    = wr_en_b_reg;
  assign wr_r_b     = wr_r_b_reg;
  assign wr_value_b = wr_value_b_reg;

  always_comb begin
    pending_mask = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      pending_mask = pending_mask | pend_onehot[s];
    end
  end

endmodule
